// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: turns button pulses into the mode_state bus, runs the timed
// modes (level-3, level-3 return, self-clean) and keeps the saturating fan-run-time total.
module hood_mode_scheduler #(
   parameter int unsigned CLK_PER_SEC = 100_000_000,
   parameter int unsigned L3_SEC      = 60,
   parameter int unsigned RET_SEC     = 60,
   parameter int unsigned CLEAN_SEC   = 180,
   parameter int unsigned REMIND_SEC  = 36000,
   parameter int unsigned ACC_W       = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             power_on,
   input  logic             btn_menu,
   input  logic             btn_l1,
   input  logic             btn_l2,
   input  logic             btn_l3,
   input  logic             btn_clean,
   output logic [2:0]       mode_state,
   output logic [11:0]      remaining_sec,
   output logic [ACC_W-1:0] accum_sec,
   output logic             clean_reminder,
   output logic             sec_tick
);

   localparam int unsigned        PRESC_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_PER_SEC - 1);
   localparam logic [ACC_W-1:0]   ACC_MAX    = {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0]   REMIND_LIM = ACC_W'(REMIND_SEC);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_STANDBY = 3'd1,
      ST_MENU    = 3'd2,
      ST_L1      = 3'd3,
      ST_L2      = 3'd4,
      ST_L3      = 3'd5,
      ST_L3_RET  = 3'd6,
      ST_CLEAN   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      BTN_NONE  = 3'd0,
      BTN_L1    = 3'd1,
      BTN_L2    = 3'd2,
      BTN_L3    = 3'd3,
      BTN_CLEAN = 3'd4,
      BTN_MENU  = 3'd5
   } btn_t;

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [11:0]        rem_q, rem_d;
   logic [ACC_W-1:0]   accum_q, accum_d;
   logic               l3_used_q, l3_used_d;
   logic               reminder_q, reminder_d;
   logic               sec_tick_q, sec_tick_d;
   logic [2:0]         mode_q, mode_d;

   btn_t               btn_s;
   logic               tick_s;
   logic               expire_s;
   logic               clear_accum_s;
   logic               entry_s;

   function automatic logic [2:0] mode_of(input state_t st);
      logic [2:0] m;
      case (st)
         ST_L1:     m = 3'b001;
         ST_L2:     m = 3'b010;
         ST_L3:     m = 3'b011;
         ST_L3_RET: m = 3'b011;
         ST_CLEAN:  m = 3'b100;
         default:   m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [11:0] load_of(input state_t st);
      logic [11:0] v;
      case (st)
         ST_L3:     v = 12'(L3_SEC);
         ST_L3_RET: v = 12'(RET_SEC);
         ST_CLEAN:  v = 12'(CLEAN_SEC);
         default:   v = 12'd0;
      endcase
      return v;
   endfunction

   function automatic logic is_timed(input state_t st);
      logic t;
      case (st)
         ST_L3, ST_L3_RET, ST_CLEAN: t = 1'b1;
         default:                    t = 1'b0;
      endcase
      return t;
   endfunction

   // Tick effects are suppressed on the power-off edge so nothing counts into OFF.
   assign tick_s   = power_on && (state_q != ST_OFF) && (presc_q == PRESC_MAX);
   assign expire_s = tick_s && is_timed(state_q) && (rem_q == 12'd1);
   assign entry_s  = (state_d != state_q);

   // Resolve same-cycle buttons to the single highest-priority press.
   always_comb begin
      btn_s = BTN_NONE;
      if (btn_menu) begin
         btn_s = BTN_MENU;
      end else if (btn_clean) begin
         btn_s = BTN_CLEAN;
      end else if (btn_l3) begin
         btn_s = BTN_L3;
      end else if (btn_l2) begin
         btn_s = BTN_L2;
      end else if (btn_l1) begin
         btn_s = BTN_L1;
      end else begin
         btn_s = BTN_NONE;
      end
   end

   // Next state: power-off, then timer expiry, then the resolved button.
   always_comb begin
      state_d       = state_q;
      clear_accum_s = 1'b0;
      if (!power_on) begin
         state_d = ST_OFF;
      end else if (state_q == ST_OFF) begin
         state_d = ST_STANDBY;
      end else if (expire_s) begin
         case (state_q)
            ST_L3:     state_d = ST_L2;
            ST_L3_RET: state_d = ST_STANDBY;
            ST_CLEAN: begin
               state_d       = ST_STANDBY;
               clear_accum_s = 1'b1;
            end
            default:   state_d = state_q;
         endcase
      end else begin
         case (state_q)
            ST_STANDBY: state_d = (btn_s == BTN_MENU) ? ST_MENU : ST_STANDBY;
            ST_MENU: begin
               case (btn_s)
                  BTN_MENU:  state_d = ST_STANDBY;
                  BTN_CLEAN: state_d = ST_CLEAN;
                  BTN_L3:    state_d = l3_used_q ? ST_MENU : ST_L3;
                  BTN_L2:    state_d = ST_L2;
                  BTN_L1:    state_d = ST_L1;
                  default:   state_d = ST_MENU;
               endcase
            end
            ST_L1, ST_L2: begin
               case (btn_s)
                  BTN_MENU: state_d = ST_STANDBY;
                  BTN_L1:   state_d = ST_L1;
                  BTN_L2:   state_d = ST_L2;
                  default:  state_d = state_q;
               endcase
            end
            ST_L3:   state_d = (btn_s == BTN_MENU) ? ST_L3_RET : ST_L3;
            default: state_d = state_q;
         endcase
      end
   end

   // Prescaler, countdown, run-time total and registered output images.
   always_comb begin
      presc_d    = presc_q;
      rem_d      = rem_q;
      accum_d    = accum_q;
      sec_tick_d = tick_s;
      mode_d     = mode_of(state_d);
      l3_used_d  = power_on ? (l3_used_q | ((state_d == ST_L3) && (state_q != ST_L3))) : 1'b0;

      if ((state_d == ST_OFF) || entry_s || (presc_q == PRESC_MAX)) begin
         presc_d = {PRESC_W{1'b0}};
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end

      if (entry_s) begin
         rem_d = load_of(state_d);
      end else if (tick_s && (rem_q != 12'd0)) begin
         rem_d = rem_q - 12'd1;
      end else begin
         rem_d = rem_q;
      end

      if (clear_accum_s) begin
         accum_d = {ACC_W{1'b0}};
      end else if (tick_s && (mode_of(state_q) != 3'b000) && (mode_of(state_q) != 3'b100)
                   && (accum_q != ACC_MAX)) begin
         accum_d = accum_q + ACC_W'(1);
      end else begin
         accum_d = accum_q;
      end

      reminder_d = (accum_d >= REMIND_LIM);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_OFF;
         presc_q    <= {PRESC_W{1'b0}};
         rem_q      <= 12'd0;
         accum_q    <= {ACC_W{1'b0}};
         l3_used_q  <= 1'b0;
         reminder_q <= 1'b0;
         sec_tick_q <= 1'b0;
         mode_q     <= 3'b000;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         rem_q      <= rem_d;
         accum_q    <= accum_d;
         l3_used_q  <= l3_used_d;
         reminder_q <= reminder_d;
         sec_tick_q <= sec_tick_d;
         mode_q     <= mode_d;
      end
   end

   assign mode_state     = mode_q;
   assign remaining_sec  = rem_q;
   assign accum_sec      = accum_q;
   assign clean_reminder = reminder_q;
   assign sec_tick       = sec_tick_q;

endmodule
